// File: rtl/block_check_scheduler_if.sv
// Requester, checker and verdict signals of the shared block-checker
// scheduler, bundled so the testbench and the top share one definition.
interface block_check_scheduler_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           chk_reset;
  logic [7:0]     chk_in;
  logic           chk_result;
  logic           resp_valid;
  logic [IDW-1:0] resp_id;
  logic           resp_ok;
  logic           resp_ovf;

  modport master (
    output req_valid, req_data, req_last, chk_result,
    input  req_ready, chk_reset, chk_in,
    input  resp_valid, resp_id, resp_ok, resp_ovf
  );

  modport slave (
    input  req_valid, req_data, req_last, chk_result,
    output req_ready, chk_reset, chk_in,
    output resp_valid, resp_id, resp_ok, resp_ovf
  );
endinterface

// File: rtl/block_check_scheduler.sv
// Round-robin scheduler sharing one begin/end checker between N requesters:
// buffers a frame, clears the checker, replays the frame, reports a verdict.
module block_check_scheduler #(
  parameter int N     = 4,
  parameter int DEPTH = 64,
  parameter int IDW   = 2
) (
  input logic                   clk,
  input logic                   reset,
  block_check_scheduler_if.slave bus
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, COLLECT, CLEAR, FEED, JUDGE, RESP
  } state_t;

  state_t st, nxt;

  logic [IDW-1:0] rr, g, pick;
  logic           found;
  logic [LW-1:0]  len, cnt, cnt_d;
  logic           ovf;
  logic [7:0]     mem [DEPTH];

  logic           gvalid, glast, xfer;
  logic [7:0]     gdata;
  logic [N-1:0]   ready;

  logic           chk_reset_q, chk_reset_d;
  logic [7:0]     chk_in_q, chk_in_d;
  logic           resp_valid_q, resp_ok_q, resp_ovf_q;
  logic [IDW-1:0] resp_id_q;

  always_comb begin
    pick  = rr;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && bus.req_valid[(int'(rr) + k) % N]) begin
        found = 1'b1;
        pick  = IDW'((int'(rr) + k) % N);
      end
    end
  end

  always_comb begin
    gvalid = 1'b0;
    glast  = 1'b0;
    gdata  = 8'h00;
    ready  = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(g) == i) begin
        gvalid   = bus.req_valid[i];
        glast    = bus.req_last[i];
        gdata    = bus.req_data[8*i +: 8];
        ready[i] = (st == COLLECT);
      end
    end
  end

  assign xfer = (st == COLLECT) && gvalid;

  always_comb begin
    nxt   = st;
    cnt_d = cnt;
    unique case (st)
      IDLE:    if (found) nxt = COLLECT;
      COLLECT: if (xfer && glast) nxt = CLEAR;
      CLEAR: begin
        cnt_d = '0;
        nxt   = ovf ? JUDGE : FEED;
      end
      FEED: begin
        if (cnt == len) nxt = JUDGE;
        else cnt_d = cnt + LW'(1);
      end
      JUDGE:   nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // The checker stays out of reset through JUDGE so its verdict survives
  // until sampled; an overflowed frame never releases it.
  always_comb begin
    chk_reset_d = 1'b1;
    chk_in_d    = 8'h20;
    if (nxt == FEED) begin
      chk_reset_d = 1'b0;
      if (cnt_d < len) chk_in_d = mem[cnt_d[AW-1:0]];
    end else if (nxt == JUDGE && !ovf) begin
      chk_reset_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer && len < FULL) mem[len[AW-1:0]] <= gdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st           <= IDLE;
      rr           <= IDW'(N - 1);
      g            <= '0;
      len          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      chk_reset_q  <= 1'b1;
      chk_in_q     <= 8'h20;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_ok_q    <= 1'b0;
      resp_ovf_q   <= 1'b0;
    end else begin
      st           <= nxt;
      cnt          <= cnt_d;
      chk_reset_q  <= chk_reset_d;
      chk_in_q     <= chk_in_d;
      resp_valid_q <= (nxt == RESP);
      if (st == IDLE && found) g <= pick;
      if (xfer) begin
        if (len < FULL) len <= len + LW'(1);
        else ovf <= 1'b1;
        if (glast) rr <= g;
      end
      if (st == JUDGE) resp_ok_q <= bus.chk_result && !ovf;
      if (nxt == RESP) begin
        resp_id_q  <= g;
        resp_ovf_q <= ovf;
      end
      if (st == RESP) begin
        len <= '0;
        ovf <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.chk_reset  = chk_reset_q;
  assign bus.chk_in     = chk_in_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_ok    = resp_ok_q;
  assign bus.resp_ovf   = resp_ovf_q;
endmodule

// File: tb/tb_block_check_scheduler.sv
// Scoreboard bench: randomized and directed frames, a streaming stand-in
// checker, and a word-level reference model of the expected verdict.
module tb_block_check_scheduler;
  localparam int N     = 4;
  localparam int DEPTH = 32;
  localparam int IDW   = 2;

  typedef struct {
    int     id;
    bit     ok;
    bit     ovf;
    longint due;
    string  frame;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset;
  longint cyc = 0;
  int     tests = 0;
  int     fails = 0;

  exp_t   sb[$];
  string  fq[N][$];
  int     pos[N];
  int     served[$];
  int     gap_pct;
  int     stall_req, stall_pos, stall_left;
  string  feed = "";

  string  cw = "";
  int     cdepth = 0;
  bit     cbad = 1'b0;

  block_check_scheduler_if #(.N(N), .IDW(IDW)) bif ();

  block_check_scheduler #(.N(N), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in checker: case-insensitive words, resolved on a non-letter.
  assign bif.chk_result = (cdepth == 0) && !cbad;
  initial forever begin
    logic [7:0] c;
    @(posedge clk or posedge bif.chk_reset);
    if (bif.chk_reset) begin
      cw = ""; cdepth = 0; cbad = 1'b0;
    end else begin
      c = bif.chk_in;
      if (c >= 8'h41 && c <= 8'h5a) c = c + 8'd32;
      if (c >= 8'h61 && c <= 8'h7a) cw = {cw, $sformatf("%c", c)};
      else begin
        if (cw == "begin") cdepth++;
        else if (cw == "end") begin
          if (cdepth == 0) cbad = 1'b1;
          else cdepth--;
        end
        cw = "";
      end
    end
  end

  task automatic chk(string name, longint act, longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_s(string name, string act, string exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    end
  endtask

  function automatic bit ref_ok(string s);
    string t = {s.tolower(), " "};
    string w = "";
    string words[$];
    int    d = 0;
    for (int k = 0; k < t.len(); k++) begin
      if (t[k] >= "a" && t[k] <= "z") w = {w, $sformatf("%c", t[k])};
      else if (w.len() > 0) begin
        words.push_back(w);
        w = "";
      end
    end
    foreach (words[k]) begin
      if (words[k] == "begin") d++;
      if (words[k] == "end") begin
        if (d == 0) return 1'b0;
        d--;
      end
    end
    return d == 0;
  endfunction

  function automatic string rand_frame();
    string toks[7] = '{"begin", "end", "BEGIN", "End", "x", "beginx", "ab"};
    string s = "";
    int    n;
    if ($urandom_range(0, 5) == 0) begin
      n = $urandom_range(DEPTH + 1, DEPTH + 8);
      for (int k = 0; k < n; k++)
        s = {s, $sformatf("%c", 8'($urandom_range(97, 122)))};
      return s;
    end
    n = $urandom_range(1, 4);
    for (int k = 0; k < n; k++) begin
      if (k > 0) s = {s, ($urandom_range(0, 1) != 0) ? " " : ";"};
      s = {s, toks[$urandom_range(0, 6)]};
    end
    return s;
  endfunction

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (fq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle of stimulus: ready is stable from negedge to the next posedge,
  // so valid&ready seen here is exactly the transfer that edge performs.
  task automatic step();
    logic [N-1:0]   v, l, rdy;
    logic [8*N-1:0] d;
    string          s;
    exp_t           e;
    @(negedge clk);
    rdy = bif.req_ready;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < N; i++) begin
      d[8*i +: 8] = 8'($urandom_range(0, 255));
      if (!reset && fq[i].size() > 0) begin
        s = fq[i][0];
        d[8*i +: 8] = s[pos[i]];
        l[i] = (pos[i] == s.len() - 1);
        v[i] = ($urandom_range(0, 99) >= gap_pct);
        if (i == stall_req && pos[i] == stall_pos && stall_left > 0) begin
          v[i] = 1'b0;
          stall_left--;
        end
        if (v[i] && rdy[i]) begin
          pos[i]++;
          if (l[i]) begin
            e.id    = i;
            e.ovf   = s.len() > DEPTH;
            e.ok    = !e.ovf && ref_ok(s);
            e.due   = cyc + 1 + (e.ovf ? 2 : s.len() + 3);
            e.frame = s;
            sb.push_back(e);
            served.push_back(i);
            void'(fq[i].pop_front());
            pos[i] = 0;
          end
        end
      end
    end
    bif.req_valid = v;
    bif.req_last  = l;
    bif.req_data  = d;
  endtask

  task automatic run(int budget);
    int n = 0;
    while ((busy() || sb.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("run_within_budget", n < budget, 1);
    repeat (3) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    for (int i = 0; i < N; i++) begin
      fq[i].delete();
      pos[i] = 0;
    end
    repeat (2) step();
    reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever a verdict pulse appears.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset) feed = "";
    else begin
      if (!bif.chk_reset) feed = {feed, $sformatf("%c", bif.chk_in)};
      chk("ready_onehot", $countones(bif.req_ready) <= 1, 1);
      if (bif.resp_valid) begin
        chk("resp_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("resp_id", bif.resp_id, e.id);
          chk("resp_ok", bif.resp_ok, e.ok);
          chk("resp_ovf", bif.resp_ovf, e.ovf);
          chk("resp_latency", cyc, e.due);
          // frame, trailing space, then the idle space seen during JUDGE
          chk_s("feed_stream", feed, e.ovf ? "" : {e.frame, "  "});
        end
        feed = "";
      end
    end
  end

  initial begin
    string big;
    int    fed, n;
    reset = 1'b1;
    bif.req_valid = '0;
    bif.req_last  = '0;
    bif.req_data  = '0;
    gap_pct = 0;
    stall_req = -1; stall_pos = 0; stall_left = 0;
    for (int i = 0; i < N; i++) pos[i] = 0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bif.req_ready, 0);
    chk("rst_chk_reset", bif.chk_reset, 1);
    chk("rst_chk_in", bif.chk_in, 8'h20);
    chk("rst_resp_valid", bif.resp_valid, 0);
    chk("rst_resp_id", bif.resp_id, 0);
    chk("rst_resp_ok", bif.resp_ok, 0);
    chk("rst_resp_ovf", bif.resp_ovf, 0);
    reset = 1'b0;

    fq[0].push_back("begin end");
    run(200);
    fq[1].push_back("BeGin");
    fq[1].push_back("end begin");
    run(300);

    do_reset();
    served.delete();
    fq[0].push_back("begin x end");
    fq[0].push_back("end");
    fq[2].push_back("begin end;");
    run(300);
    chk("arb_count", served.size(), 3);
    if (served.size() == 3) begin
      chk("arb_first", served[0], 0);
      chk("arb_second", served[1], 2);
      chk("arb_third", served[2], 0);
    end

    gap_pct = 30;
    big = "";
    for (int k = 0; k < 40; k++)
      big = {big, $sformatf("%c", 8'($urandom_range(97, 122)))};
    fq[3].push_back(big);
    big = "begin";
    while (big.len() < DEPTH - 3) big = {big, " "};
    fq[3].push_back({big, "end"});
    fq[3].push_back({big, " end"});
    run(1000);

    gap_pct = 0;
    fq[2].push_back("begin  end");
    fed = 0; n = 0;
    while (fed < 3 && n < 200) begin
      step();
      if (!bif.chk_reset) fed++;
      n++;
    end
    chk("feed_reached", fed, 3);
    reset = 1'b1;
    #1;
    chk("midreset_chk_reset", bif.chk_reset, 1);
    chk("midreset_req_ready", bif.req_ready, 0);
    sb.delete();
    for (int i = 0; i < N; i++) begin
      fq[i].delete();
      pos[i] = 0;
    end
    repeat (3) step();
    reset = 1'b0;
    repeat (20) step();
    fq[2].push_back("begin end");
    run(200);

    stall_req = 1; stall_pos = 8; stall_left = 5;
    fq[1].push_back("begin begin end end");
    run(300);
    chk("stall_used", stall_left, 0);
    stall_req = -1;

    gap_pct = 25;
    repeat (40) fq[$urandom_range(0, N - 1)].push_back(rand_frame());
    run(20000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
